// File: rtl/set_job_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : set_job_scheduler
// Purpose  : Round-robin front end that shares one SET engine between NREQ
//            requesters and returns tagged counts on a valid/ready port.
//            Define SET_TIMEOUT_EN to add the WAIT-state watchdog.
// Revision : 1.0
// ============================================================================
module set_job_scheduler #(
    parameter int NREQ        = 2,
    parameter int TIMEOUT_CYC = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [16*NREQ-1:0]   req_central,
    input  logic [8*NREQ-1:0]    req_radius,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [1:0]           resp_id,
    output logic [3:0]           resp_count,
    output logic                 resp_err,
    output logic                 eng_en,
    output logic [15:0]          eng_central,
    output logic [7:0]           eng_radius,
    input  logic                 eng_busy,
    input  logic                 eng_valid,
    input  logic [3:0]           eng_candidate,
    output logic                 sched_busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  rr_ptr_q, rr_ptr_d;
    logic [1:0]  id_q, id_d;
    logic [3:0]  count_q, count_d;
    logic        err_q, err_d;
    logic [15:0] central_q, central_d;
    logic [7:0]  radius_q, radius_d;

    logic            grant_vld;
    logic [1:0]      grant_idx;
    logic [NREQ-1:0] grant_oh;
    logic [15:0]     grant_central;
    logic [7:0]      grant_radius;
    logic            grant_take;
    logic            radius_ok;

`ifdef SET_TIMEOUT_EN
    logic [7:0] wdog_q, wdog_d;
    logic [7:0] wdog_inc;
    assign wdog_inc = wdog_q + 8'd1;
`endif

    function automatic logic nib_ok(input logic [3:0] r);
        return (r != 4'd0) && (r <= 4'd9);
    endfunction

    // Scan from rr_ptr upward (mod NREQ); the first valid requester wins.
    always_comb begin : arbiter
        int idx;
        idx           = 0;
        grant_vld     = 1'b0;
        grant_idx     = 2'd0;
        grant_oh      = '0;
        grant_central = 16'd0;
        grant_radius  = 8'd0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            for (int i = 0; i < NREQ; i++) begin
                if (!grant_vld && idx == i && req_valid[i]) begin
                    grant_vld     = 1'b1;
                    grant_idx     = 2'(i);
                    grant_oh[i]   = 1'b1;
                    grant_central = req_central[16*i +: 16];
                    grant_radius  = req_radius[8*i +: 8];
                end
            end
        end
    end

    assign grant_take = (state_q == S_IDLE) && !eng_busy && grant_vld;
    assign radius_ok  = nib_ok(grant_radius[7:4]) && nib_ok(grant_radius[3:0]);
    // Gated by rst so the combinational accept is also silent during reset.
    assign req_ready  = (grant_take && rst) ? grant_oh : '0;

    always_comb begin : fsm_next
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        id_d      = id_q;
        count_d   = count_q;
        err_d     = err_q;
        central_d = central_q;
        radius_d  = radius_q;
`ifdef SET_TIMEOUT_EN
        wdog_d    = wdog_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (grant_take) begin
                    central_d = grant_central;
                    radius_d  = grant_radius;
                    id_d      = grant_idx;
                    rr_ptr_d  = (grant_idx == 2'(NREQ-1)) ? 2'd0 : grant_idx + 2'd1;
                    if (radius_ok) begin
                        state_d = S_ISSUE;
                    end else begin
                        count_d = 4'd0;
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end
                end
            end
            S_ISSUE: begin
`ifdef SET_TIMEOUT_EN
                wdog_d  = 8'd0;
`endif
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (eng_valid) begin
                    count_d = eng_candidate;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end
`ifdef SET_TIMEOUT_EN
                else begin
                    wdog_d = wdog_inc;
                    if (wdog_inc == 8'(TIMEOUT_CYC)) begin
                        count_d = 4'd0;
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end
                end
`endif
            end
            S_RESP: begin
                if (resp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            rr_ptr_q  <= 2'd0;
            id_q      <= 2'd0;
            count_q   <= 4'd0;
            err_q     <= 1'b0;
            central_q <= 16'd0;
            radius_q  <= 8'd0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            id_q      <= id_d;
            count_q   <= count_d;
            err_q     <= err_d;
            central_q <= central_d;
            radius_q  <= radius_d;
        end
    end

`ifdef SET_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) wdog_q <= 8'd0;
        else      wdog_q <= wdog_d;
    end
`endif

    assign resp_valid  = (state_q == S_RESP);
    assign resp_id     = id_q;
    assign resp_count  = count_q;
    assign resp_err    = err_q;
    assign eng_en      = (state_q == S_ISSUE);
    assign eng_central = central_q;
    assign eng_radius  = radius_q;
    assign sched_busy  = (state_q != S_IDLE);

endmodule
`default_nettype wire
